// File: rtl/utest_checkpoint_monitor.sv
// Checkpoint monitor for microcode self-tests: watches the retirement trace,
// matches pass/skip/fail tables, issues skip redirects and reports a verdict.
module utest_checkpoint_monitor #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned N_PASS      = 16,
  parameter int unsigned N_SKIP      = 8,
  parameter int unsigned N_FAIL      = 4,
  parameter int unsigned LIMIT_W     = 32,
  parameter bit          REQUIRE_ALL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              retired,
  input  logic [ADDR_W-1:0] pc_x,
  input  logic [112:1]      opcode_x,
  input  logic [ADDR_W-1:0] pc_f,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [3:0]        cfg_idx,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_a,
  input  logic [ADDR_W-1:0] cfg_b,
  input  logic [ADDR_W-1:0] cfg_c,
  input  logic              start,
  input  logic              clear,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  input  logic              redirect_ack,
  output logic              pass_stb,
  output logic [3:0]        pass_idx,
  output logic [N_PASS-1:0] hit_mask,
  output logic [7:0]        pass_count,
  output logic [7:0]        skip_count,
  output logic [2:0]        state,
  output logic              done,
  output logic [ADDR_W-1:0] fail_pc
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_REDIRECT = 3'd2,
    S_PASSED   = 3'd3,
    S_FAILED   = 3'd4,
    S_TIMEOUT  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Programmable tables
  logic [N_PASS-1:0]  pass_vld_q;
  logic [ADDR_W-1:0]  pass_lbl_q [N_PASS];
  logic [N_SKIP-1:0]  skip_vld_q;
  logic [ADDR_W-1:0]  skip_from_q [N_SKIP];
  logic [ADDR_W-1:0]  skip_to_q [N_SKIP];
  logic [ADDR_W-1:0]  skip_tgt_q [N_SKIP];
  logic [N_FAIL-1:0]  fail_vld_q;
  logic [ADDR_W-1:0]  fail_lbl_q [N_FAIL];
  logic [ADDR_W-1:0]  end_lbl_q;
  logic [LIMIT_W-1:0] limit_q;

  // Run bookkeeping
  logic [LIMIT_W-1:0] cyc_q, cyc_d, cyc_inc;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;

  // Next values of registered outputs
  logic              redirect_valid_d, pass_stb_d, done_d;
  logic [ADDR_W-1:0] redirect_addr_d, fail_pc_d;
  logic [IDX_W-1:0]  pass_idx_d;
  logic [N_PASS-1:0] hit_mask_d;
  logic [CNT_W-1:0]  pass_count_d, skip_count_d;

  // Match results
  logic              fail_hit, end_hit, all_hit, skip_hit, pass_hit, pass_new;
  logic              pass_form, limit_hit;
  logic [ADDR_W-1:0] skip_tgt;
  logic [IDX_W-1:0]  pass_sel;
  logic [N_PASS-1:0] pass_onehot;

  // Only the CONT-form fields of the opcode are inspected
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode_x[94:1];

  assign state = 3'(state_q);

  // Table writes, accepted only while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_vld_q <= '0;
      skip_vld_q <= '0;
      fail_vld_q <= '0;
      end_lbl_q  <= '0;
      limit_q    <= '0;
      for (int i = 0; i < int'(N_PASS); i++) pass_lbl_q[i] <= '0;
      for (int i = 0; i < int'(N_SKIP); i++) begin
        skip_from_q[i] <= '0;
        skip_to_q[i]   <= '0;
        skip_tgt_q[i]  <= '0;
      end
      for (int i = 0; i < int'(N_FAIL); i++) fail_lbl_q[i] <= '0;
    end else if (cfg_we && state_q == S_IDLE) begin
      case (cfg_sel)
        2'd0: begin
          for (int i = 0; i < int'(N_PASS); i++) begin
            if (cfg_idx == IDX_W'(i)) begin
              pass_vld_q[i] <= cfg_valid;
              pass_lbl_q[i] <= cfg_a;
            end
          end
        end
        2'd1: begin
          for (int i = 0; i < int'(N_SKIP); i++) begin
            if (cfg_idx == IDX_W'(i)) begin
              skip_vld_q[i]  <= cfg_valid;
              skip_from_q[i] <= cfg_a;
              skip_to_q[i]   <= cfg_b;
              skip_tgt_q[i]  <= cfg_c;
            end
          end
        end
        2'd2: begin
          for (int i = 0; i < int'(N_FAIL); i++) begin
            if (cfg_idx == IDX_W'(i)) begin
              fail_vld_q[i] <= cfg_valid;
              fail_lbl_q[i] <= cfg_a;
            end
          end
        end
        default: begin
          end_lbl_q <= cfg_a;
          limit_q   <= LIMIT_W'({cfg_c, cfg_b});
        end
      endcase
    end
  end

  // Table lookups against the current retirement; lowest index wins
  always_comb begin
    fail_hit = 1'b0;
    for (int i = 0; i < int'(N_FAIL); i++) begin
      if (fail_vld_q[i] && fail_lbl_q[i] == pc_x) fail_hit = 1'b1;
    end

    skip_hit = 1'b0;
    skip_tgt = '0;
    for (int i = int'(N_SKIP) - 1; i >= 0; i--) begin
      if (skip_vld_q[i] && skip_from_q[i] == pc_x && skip_to_q[i] == pc_f) begin
        skip_hit = 1'b1;
        skip_tgt = skip_tgt_q[i];
      end
    end

    pass_form   = (opcode_x[112:109] == 4'd14) && (opcode_x[96:95] == 2'd0);
    pass_hit    = 1'b0;
    pass_sel    = '0;
    pass_onehot = '0;
    for (int i = int'(N_PASS) - 1; i >= 0; i--) begin
      if (pass_form && pass_vld_q[i] && pass_lbl_q[i] == ADDR_W'(opcode_x[108:97])) begin
        pass_hit       = 1'b1;
        pass_sel       = IDX_W'(i);
        pass_onehot    = '0;
        pass_onehot[i] = 1'b1;
      end
    end
    pass_new = pass_hit && ((hit_mask & pass_onehot) == '0);

    end_hit   = (pc_x == end_lbl_q);
    all_hit   = ((hit_mask & pass_vld_q) == pass_vld_q);
    cyc_inc   = cyc_q + LIMIT_W'(1);
    limit_hit = (limit_q != '0) && (cyc_inc == limit_q);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      pass_stb       <= 1'b0;
      pass_idx       <= '0;
      hit_mask       <= '0;
      pass_count     <= '0;
      skip_count     <= '0;
      done           <= 1'b0;
      fail_pc        <= '0;
      cyc_q          <= '0;
      last_pc_q      <= '0;
    end else begin
      state_q        <= state_d;
      redirect_valid <= redirect_valid_d;
      redirect_addr  <= redirect_addr_d;
      pass_stb       <= pass_stb_d;
      pass_idx       <= pass_idx_d;
      hit_mask       <= hit_mask_d;
      pass_count     <= pass_count_d;
      skip_count     <= skip_count_d;
      done           <= done_d;
      fail_pc        <= fail_pc_d;
      cyc_q          <= cyc_d;
      last_pc_q      <= last_pc_d;
    end
  end

  // Next state: fail/end beat the limit, the limit beats a skip
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !clear) state_d = S_RUN;
      end
      S_RUN: begin
        if (retired && fail_hit)             state_d = S_FAILED;
        else if (retired && end_hit)         state_d = (REQUIRE_ALL && !all_hit) ? S_FAILED : S_PASSED;
        else if (limit_hit)                  state_d = S_TIMEOUT;
        else if (retired && skip_hit)        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (limit_hit)         state_d = S_TIMEOUT;
        else if (redirect_ack) state_d = S_RUN;
      end
      S_PASSED, S_FAILED, S_TIMEOUT: begin
        if (clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and bookkeeping updates for the coming cycle
  always_comb begin
    redirect_valid_d = (state_d == S_REDIRECT);
    done_d           = (state_d == S_PASSED) || (state_d == S_FAILED) || (state_d == S_TIMEOUT);
    redirect_addr_d  = redirect_addr;
    pass_stb_d       = 1'b0;
    pass_idx_d       = pass_idx;
    hit_mask_d       = hit_mask;
    pass_count_d     = pass_count;
    skip_count_d     = skip_count;
    fail_pc_d        = fail_pc;
    cyc_d            = cyc_q;
    last_pc_d        = last_pc_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_RUN) begin
          hit_mask_d   = '0;
          pass_count_d = '0;
          skip_count_d = '0;
          fail_pc_d    = '0;
          cyc_d        = '0;
          last_pc_d    = '0;
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (retired) last_pc_d = pc_x;
        if (state_d == S_FAILED)  fail_pc_d = pc_x;
        if (state_d == S_TIMEOUT) fail_pc_d = retired ? pc_x : last_pc_q;
        if (retired && !fail_hit && !end_hit && pass_hit) begin
          pass_stb_d = 1'b1;
          pass_idx_d = pass_sel;
          if (pass_new) begin
            hit_mask_d   = hit_mask | pass_onehot;
            pass_count_d = pass_count + CNT_W'(1);
          end
        end
        if (state_d == S_REDIRECT) begin
          redirect_addr_d = skip_tgt;
          if (skip_count != '1) skip_count_d = skip_count + CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        cyc_d = cyc_inc;
        if (state_d == S_TIMEOUT) fail_pc_d = last_pc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_utest_checkpoint_monitor.sv
// Bench for utest_checkpoint_monitor: directed scenarios plus a randomized
// run against a behavioural model of the non-REQUIRE_ALL instance.
module tb_utest_checkpoint_monitor;

  logic         clk = 1'b0;
  logic         reset, retired, cfg_we, cfg_valid, start, clear, redirect_ack;
  logic [11:0]  pc_x, pc_f, cfg_a, cfg_b, cfg_c;
  logic [112:1] opcode_x;
  logic [1:0]   cfg_sel;
  logic [3:0]   cfg_idx;

  logic         a_rv, a_stb, a_done, b_rv, b_stb, b_done;
  logic [11:0]  a_raddr, a_fpc, b_raddr, b_fpc;
  logic [3:0]   a_pidx, b_pidx;
  logic [15:0]  a_hit, b_hit;
  logic [7:0]   a_pcnt, a_scnt, b_pcnt, b_scnt;
  logic [2:0]   a_state, b_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  utest_checkpoint_monitor #(.REQUIRE_ALL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .retired(retired), .pc_x(pc_x), .opcode_x(opcode_x),
    .pc_f(pc_f), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_valid(cfg_valid), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
    .start(start), .clear(clear), .redirect_valid(a_rv), .redirect_addr(a_raddr),
    .redirect_ack(redirect_ack), .pass_stb(a_stb), .pass_idx(a_pidx),
    .hit_mask(a_hit), .pass_count(a_pcnt), .skip_count(a_scnt), .state(a_state),
    .done(a_done), .fail_pc(a_fpc));

  utest_checkpoint_monitor #(.REQUIRE_ALL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .retired(retired), .pc_x(pc_x), .opcode_x(opcode_x),
    .pc_f(pc_f), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_valid(cfg_valid), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
    .start(start), .clear(clear), .redirect_valid(b_rv), .redirect_addr(b_raddr),
    .redirect_ack(redirect_ack), .pass_stb(b_stb), .pass_idx(b_pidx),
    .hit_mask(b_hit), .pass_count(b_pcnt), .skip_count(b_scnt), .state(b_state),
    .done(b_done), .fail_pc(b_fpc));

  // ---------------- behavioural model (REQUIRE_ALL = 0) ----------------
  int          m_state, m_pcount, m_scount, m_pidx, m_raddr, m_fpc, m_last, m_end;
  logic [15:0] m_hit;
  bit          m_stb;
  longint      m_cyc, m_lim;
  bit          m_pv[16], m_sv[8], m_fv[4];
  int          m_pl[16], m_sf[8], m_st[8], m_sg[8], m_fl[4];

  always @(posedge clk) begin : model
    bit f, timeout;
    int pi, sg, ix;
    if (reset) begin
      m_state = 0; m_hit = '0; m_pcount = 0; m_scount = 0; m_stb = 0; m_pidx = 0;
      m_raddr = 0; m_fpc = 0; m_last = 0; m_end = 0; m_cyc = 0; m_lim = 0;
      foreach (m_pv[i]) m_pv[i] = 0;
      foreach (m_sv[i]) m_sv[i] = 0;
      foreach (m_fv[i]) m_fv[i] = 0;
    end else begin
      m_stb = 0;
      case (m_state)
        0: begin
          if (cfg_we) begin
            ix = int'(cfg_idx);
            case (cfg_sel)
              2'd0: if (ix < 16) begin m_pv[ix] = cfg_valid; m_pl[ix] = int'(cfg_a); end
              2'd1: if (ix < 8) begin
                m_sv[ix] = cfg_valid; m_sf[ix] = int'(cfg_a);
                m_st[ix] = int'(cfg_b); m_sg[ix] = int'(cfg_c);
              end
              2'd2: if (ix < 4) begin m_fv[ix] = cfg_valid; m_fl[ix] = int'(cfg_a); end
              default: begin m_end = int'(cfg_a); m_lim = longint'({cfg_c, cfg_b}); end
            endcase
          end
          if (start && !clear) begin
            m_state = 1; m_hit = '0; m_pcount = 0; m_scount = 0; m_fpc = 0; m_cyc = 0; m_last = 0;
          end
        end
        1: begin
          m_cyc++;
          timeout = (m_lim != 0) && (m_cyc == m_lim);
          if (retired) begin
            m_last = int'(pc_x);
            f = 0;
            foreach (m_fv[i]) if (m_fv[i] && m_fl[i] == int'(pc_x)) f = 1;
            if (f) begin
              m_state = 4; m_fpc = int'(pc_x);
            end else if (int'(pc_x) == m_end) begin
              m_state = 3;
            end else begin
              pi = -1;
              if (opcode_x[112:109] == 4'd14 && opcode_x[96:95] == 2'd0)
                for (int i = 0; i < 16; i++)
                  if (m_pv[i] && m_pl[i] == int'(opcode_x[108:97])) begin pi = i; break; end
              if (pi >= 0) begin
                m_stb = 1; m_pidx = pi;
                if (!m_hit[pi]) begin m_hit[pi] = 1'b1; m_pcount++; end
              end
              sg = -1;
              for (int i = 0; i < 8; i++)
                if (m_sv[i] && m_sf[i] == int'(pc_x) && m_st[i] == int'(pc_f)) begin sg = m_sg[i]; break; end
              if (timeout) begin
                m_state = 5; m_fpc = int'(pc_x);
              end else if (sg >= 0) begin
                m_state = 2; m_raddr = sg;
                if (m_scount < 255) m_scount++;
              end
            end
          end else if (timeout) begin
            m_state = 5; m_fpc = m_last;
          end
        end
        2: begin
          m_cyc++;
          if (m_lim != 0 && m_cyc == m_lim) begin m_state = 5; m_fpc = m_last; end
          else if (redirect_ack) m_state = 1;
        end
        default: if (clear) m_state = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; retired = 0; cfg_we = 0; cfg_valid = 0; start = 0; clear = 0;
    redirect_ack = 0; pc_x = '0; pc_f = '0; cfg_a = '0; cfg_b = '0; cfg_c = '0;
    opcode_x = '0; cfg_sel = '0; cfg_idx = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic cfg_write(input int sel, input int idx, input bit v, input int a, input int b, input int c);
    cfg_we = 1; cfg_sel = 2'(sel); cfg_idx = 4'(idx); cfg_valid = v;
    cfg_a = 12'(a); cfg_b = 12'(b); cfg_c = 12'(c);
    tick();
    cfg_we = 0;
  endtask

  task automatic start_run();
    start = 1;
    tick();
    start = 0;
  endtask

  function automatic logic [112:1] mk_op(input int lbl, input int sqi, input int map);
    logic [112:1] o;
    o = '0;
    o[112:109] = 4'(sqi);
    o[108:97]  = 12'(lbl);
    o[96:95]   = 2'(map);
    return o;
  endfunction

  task automatic retire(input int pc, input int pcf, input logic [112:1] op);
    retired = 1; pc_x = 12'(pc); pc_f = 12'(pcf); opcode_x = op;
    tick();
    retired = 0; opcode_x = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    tests++; if (a_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", a_state); end
    tests++; if ({a_rv, a_done, a_stb} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {a_rv, a_done, a_stb}); end
    tests++; if ({a_raddr, a_pidx, a_hit, a_pcnt, a_scnt, a_fpc} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {a_raddr, a_pidx, a_hit, a_pcnt, a_scnt, a_fpc}); end
  endtask

  task automatic test_pass();
    do_reset();
    cfg_write(0, 0, 1, 12, 0, 0);
    cfg_write(3, 0, 0, 4000, 0, 0);
    start_run();
    tests++; if (a_state !== 3'd1) begin fails++; $display("FAIL pass_run: got %0d expected 1", a_state); end
    retire(100, 0, mk_op(12, 14, 0));
    tests++; if ({a_stb, a_pidx, a_pcnt, a_hit} !== {1'b1, 4'd0, 8'd1, 16'h0001}) begin
      fails++; $display("FAIL pass_first: got stb=%b idx=%0d cnt=%0d mask=%h expected 1 0 1 0001", a_stb, a_pidx, a_pcnt, a_hit); end
    tick();
    tests++; if (a_stb !== 1'b0) begin fails++; $display("FAIL pass_pulse_width: got %b expected 0", a_stb); end
    retire(101, 0, mk_op(12, 14, 0));
    tests++; if ({a_stb, a_pcnt} !== {1'b1, 8'd1}) begin
      fails++; $display("FAIL pass_repeat: got stb=%b cnt=%0d expected 1 1", a_stb, a_pcnt); end
    retire(102, 0, mk_op(12, 14, 2));
    tests++; if (a_stb !== 1'b0) begin fails++; $display("FAIL pass_bad_map: got %b expected 0", a_stb); end
    retire(103, 0, mk_op(12, 13, 0));
    tests++; if (a_stb !== 1'b0) begin fails++; $display("FAIL pass_bad_sqi: got %b expected 0", a_stb); end
  endtask

  task automatic test_skip();
    do_reset();
    cfg_write(1, 0, 1, 43, 44, 53);
    cfg_write(3, 0, 0, 4000, 0, 0);
    start_run();
    retire(43, 44, '0);
    tests++; if ({a_rv, a_raddr, a_state} !== {1'b1, 12'd53, 3'd2}) begin
      fails++; $display("FAIL skip_issue: got rv=%b addr=%0d st=%0d expected 1 53 2", a_rv, a_raddr, a_state); end
    for (int k = 0; k < 3; k++) begin
      retired = 1; pc_x = 12'd4000;
      tick();
      tests++; if ({a_rv, a_state} !== {1'b1, 3'd2}) begin
        fails++; $display("FAIL skip_hold%0d: got rv=%b st=%0d expected 1 2", k, a_rv, a_state); end
    end
    retired = 0; redirect_ack = 1;
    tick();
    redirect_ack = 0;
    tests++; if ({a_rv, a_state, a_scnt} !== {1'b0, 3'd1, 8'd1}) begin
      fails++; $display("FAIL skip_ack: got rv=%b st=%0d cnt=%0d expected 0 1 1", a_rv, a_state, a_scnt); end
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
    tests++; if (a_state !== 3'd1) begin fails++; $display("FAIL skip_stray_ack: got %0d expected 1", a_state); end
    retire(43, 45, '0);
    tests++; if (a_state !== 3'd1) begin fails++; $display("FAIL skip_to_mismatch: got %0d expected 1", a_state); end
  endtask

  task automatic test_fail();
    do_reset();
    cfg_write(2, 0, 1, 1666, 0, 0);
    cfg_write(3, 0, 0, 4000, 0, 0);
    start_run();
    cfg_write(2, 1, 1, 300, 0, 0);
    retire(300, 0, '0);
    tests++; if (a_state !== 3'd1) begin fails++; $display("FAIL fail_cfg_locked: got %0d expected 1", a_state); end
    retire(1666, 0, '0);
    tests++; if ({a_state, a_fpc, a_done} !== {3'd4, 12'd1666, 1'b1}) begin
      fails++; $display("FAIL fail_hit: got st=%0d pc=%0d done=%b expected 4 1666 1", a_state, a_fpc, a_done); end
    start_run();
    tests++; if (a_state !== 3'd4) begin fails++; $display("FAIL fail_start_ignored: got %0d expected 4", a_state); end
    clear = 1; tick(); clear = 0;
    tests++; if ({a_state, a_done} !== {3'd0, 1'b0}) begin
      fails++; $display("FAIL fail_clear: got st=%0d done=%b expected 0 0", a_state, a_done); end
    start = 1; clear = 1; tick(); start = 0; clear = 0;
    tests++; if (a_state !== 3'd0) begin fails++; $display("FAIL start_clear_same: got %0d expected 0", a_state); end
    start_run();
    retire(1666, 0, '0);
    tests++; if (a_state !== 3'd4) begin fails++; $display("FAIL fail_table_kept: got %0d expected 4", a_state); end
  endtask

  task automatic test_require_all();
    do_reset();
    cfg_write(0, 0, 1, 5, 0, 0);
    cfg_write(0, 1, 1, 6, 0, 0);
    cfg_write(3, 0, 0, 1564, 0, 0);
    start_run();
    retire(200, 0, mk_op(5, 14, 0));
    retire(1564, 0, '0);
    tests++; if ({b_state, b_fpc, a_state} !== {3'd4, 12'd1564, 3'd3}) begin
      fails++; $display("FAIL reqall_partial: got b=%0d bpc=%0d a=%0d expected 4 1564 3", b_state, b_fpc, a_state); end
    clear = 1; tick(); clear = 0;
    start_run();
    retire(200, 0, mk_op(5, 14, 0));
    retire(201, 0, mk_op(6, 14, 0));
    retire(1564, 0, '0);
    tests++; if ({b_state, b_pcnt, a_state} !== {3'd3, 8'd2, 3'd3}) begin
      fails++; $display("FAIL reqall_full: got b=%0d cnt=%0d a=%0d expected 3 2 3", b_state, b_pcnt, a_state); end
  endtask

  task automatic test_timeout();
    do_reset();
    cfg_write(2, 0, 1, 1666, 0, 0);
    cfg_write(3, 0, 0, 4000, 100, 0);
    start_run();
    for (int k = 1; k <= 99; k++) begin
      retired = (k == 10); pc_x = 12'd77;
      tick();
    end
    retired = 0;
    tests++; if (a_state !== 3'd1) begin fails++; $display("FAIL timeout_early: got %0d expected 1", a_state); end
    tick();
    tests++; if ({a_state, a_done, a_fpc} !== {3'd5, 1'b1, 12'd77}) begin
      fails++; $display("FAIL timeout_hit: got st=%0d done=%b pc=%0d expected 5 1 77", a_state, a_done, a_fpc); end
    clear = 1; tick(); clear = 0;
    start_run();
    repeat (99) tick();
    retired = 1; pc_x = 12'd1666;
    tick();
    retired = 0;
    tests++; if ({a_state, a_fpc} !== {3'd4, 12'd1666}) begin
      fails++; $display("FAIL timeout_vs_fail: got st=%0d pc=%0d expected 4 1666", a_state, a_fpc); end
  endtask

  task automatic test_reset_in_redirect();
    do_reset();
    cfg_write(0, 0, 1, 12, 0, 0);
    cfg_write(1, 0, 1, 43, 44, 53);
    cfg_write(3, 0, 0, 4000, 0, 0);
    start_run();
    retire(43, 44, mk_op(12, 14, 0));
    tests++; if ({a_rv, a_stb} !== 2'b11) begin
      fails++; $display("FAIL skip_and_pass: got rv=%b stb=%b expected 1 1", a_rv, a_stb); end
    reset = 1; tick(); reset = 0;
    tests++; if ({a_state, a_rv, a_done, a_stb, a_raddr, a_pidx, a_hit, a_pcnt, a_scnt, a_fpc} !== '0) begin
      fails++; $display("FAIL reset_mid_redirect: got st=%0d rv=%b other=%h expected all 0", a_state, a_rv,
                        {a_raddr, a_pidx, a_hit, a_pcnt, a_scnt, a_fpc}); end
    start_run();
    retire(43, 44, mk_op(12, 14, 0));
    tests++; if ({a_state, a_stb} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL reset_tables_cleared: got st=%0d stb=%b expected 1 0", a_state, a_stb); end
  endtask

  task automatic test_random();
    logic [65:0] exp_v, act_v;
    bit          last;
    do_reset();
    for (int ep = 0; ep < 40; ep++) begin
      for (int c = 0; c < 130; c++) begin
        idle_inputs();
        last = 0;
        if (c < 8) begin
          cfg_we = 1; cfg_sel = 2'($urandom_range(0, 3)); cfg_idx = 4'($urandom_range(0, 15));
          cfg_valid = ($urandom_range(0, 3) != 0);
          cfg_a = 12'($urandom_range(0, 15)); cfg_b = 12'($urandom_range(0, 15)); cfg_c = 12'($urandom_range(0, 15));
          if (cfg_sel == 2'd3) begin
            cfg_a = 12'($urandom_range(0, 31)); cfg_b = 12'($urandom_range(0, 60)); cfg_c = '0;
          end
        end else if (c == 8) begin
          start = 1;
        end else if (c == 129 || m_state >= 3) begin
          last = 1;
          if (m_state >= 3) clear = 1; else reset = 1;
        end else begin
          retired = ($urandom_range(0, 1) == 1);
          pc_x = 12'($urandom_range(0, 15)); pc_f = 12'($urandom_range(0, 15));
          opcode_x = mk_op($urandom_range(0, 15),
                           ($urandom_range(0, 3) != 0) ? 14 : $urandom_range(0, 15),
                           ($urandom_range(0, 3) != 0) ? 0 : $urandom_range(0, 3));
          redirect_ack = ($urandom_range(0, 2) == 0);
          start = ($urandom_range(0, 9) == 0);
          clear = ($urandom_range(0, 19) == 0);
          cfg_we = ($urandom_range(0, 9) == 0);
          cfg_sel = 2'($urandom_range(0, 3)); cfg_idx = 4'($urandom_range(0, 15)); cfg_valid = 1;
          cfg_a = 12'($urandom_range(0, 15));
        end
        tick();
        exp_v = {3'(m_state), 1'(m_state >= 3), 1'(m_state == 2), 12'(m_raddr), m_stb, 4'(m_pidx),
                 m_hit, 8'(m_pcount), 8'(m_scount), 12'(m_fpc)};
        act_v = {a_state, a_done, a_rv, a_raddr, a_stb, a_pidx, a_hit, a_pcnt, a_scnt, a_fpc};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL random ep%0d cyc%0d: got %h expected %h", ep, c, act_v, exp_v);
        end
        if (last) break;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_skip();
    test_fail();
    test_require_all();
    test_timeout();
    test_reset_in_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/utest_checkpoint_monitor.md
# utest_checkpoint_monitor

Synthesizable checkpoint monitor for microcode self-tests, sitting beside `cpu` and observing its retirement trace. It matches retired microinstructions against programmable pass, skip and fail tables and issues skip redirects to the microsequencer. It also enforces a cycle limit and reports a final verdict. This lets sectest-style microcode suites run unattended on FPGA or in simulation without per-test bench code.

## Interface
Parameters:
- `ADDR_W`, 12, microcode address width.
- `N_PASS`, 16, pass-checkpoint table entries.
- `N_SKIP`, 8, skip-rule table entries.
- `N_FAIL`, 4, fail-label table entries.
- `LIMIT_W`, 32, cycle-limit counter width.
- `REQUIRE_ALL`, 0, when 1, reaching the end label with any valid pass entry unhit yields FAILED.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `retired`  in  1  one-cycle strobe: an instruction retired this cycle.
- `pc_x`  in  ADDR_W  PC of the retiring instruction.
- `opcode_x`  in  112  opcode of the retiring instruction, bits [112:1].
- `pc_f`  in  ADDR_W  PC currently being fetched.
- `cfg_we`  in  1  table write strobe.
- `cfg_sel`  in  2  target: 0 pass, 1 skip, 2 fail, 3 end-label/limit.
- `cfg_idx`  in  4  entry index. Indices at or beyond table size are ignored.
- `cfg_valid`  in  1  entry valid bit.
- `cfg_a`, `cfg_b`, `cfg_c`  in  ADDR_W each  field values:
  - pass/fail: label in `cfg_a`.
  - skip: from, to, target.
  - sel 3: end label in `cfg_a`; limit = {`cfg_c`,`cfg_b`} truncated or zero-extended to LIMIT_W.
- `start`  in  1  IDLE→RUN.
- `clear`  in  1  any terminal state→IDLE.
- `redirect_valid`  out  1  request that the sequencer jump to `redirect_addr`.
- `redirect_addr`  out  ADDR_W  jump target.
- `redirect_ack`  in  1  sequencer has taken the jump.
- `pass_stb`  out  1  one-cycle pulse on a pass-checkpoint match.
- `pass_idx`  out  4  index of the matching pass entry.
- `hit_mask`  out  N_PASS  sticky per-entry hit flags.
- `pass_count`  out  8  number of distinct pass entries hit.
- `skip_count`  out  8  number of redirects issued (saturates at 255).
- `state`  out  3  0 IDLE, 1 RUN, 2 REDIRECT, 3 PASSED, 4 FAILED, 5 TIMEOUT.
- `done`  out  1  high in PASSED, FAILED or TIMEOUT.
- `fail_pc`  out  ADDR_W  `pc_x` latched on entry to FAILED, or PC of the last retirement on TIMEOUT.

## Operation
Reset:
- All table entries invalid; end label 0; limit 0; state IDLE.
- All outputs 0.

Configuration:
- `cfg_we` is honoured only in IDLE and ignored in every other state.

`start` in IDLE:
- Clears `hit_mask`, both counters, `fail_pc` and the cycle counter.
- Enters RUN.

While in RUN, on `retired`, the first matching rule applies, in this priority order:
1. Fail: a valid fail entry equals `pc_x` → FAILED.
2. End: `pc_x` equals the end label → PASSED, unless `REQUIRE_ALL` is set and `hit_mask` is not a superset of the valid pass entries, in which case → FAILED.
3. Skip: the lowest-index valid skip entry with from==`pc_x` and to==`pc_f` → REDIRECT, `redirect_addr`=target, `skip_count`++.
4. Pass: `opcode_x[112:109]`==14, `opcode_x[96:95]`==0, and `opcode_x[108:97]` equals a valid pass label. The lowest matching index wins: `pass_stb` pulses and `pass_idx` is set. If that entry was not already hit, the corresponding `hit_mask` bit is set and `pass_count`++.

Rules 3 and 4 are independent, so a single retirement may both pulse `pass_stb` and start a redirect.

REDIRECT:
- `redirect_valid`=1 and held until `redirect_ack`, then → RUN.
- `retired` is ignored while in REDIRECT, because the pipeline is being flushed.

Cycle limit:
- The cycle counter increments every clock in RUN and REDIRECT.
- When the limit is nonzero and the counter reaches it → TIMEOUT, and `redirect_valid` drops.
- A limit of 0 disables the timeout.

Terminal states:
- PASSED, FAILED and TIMEOUT hold until `clear` or `reset`.
- `clear` returns to IDLE; table contents are kept.

## Timing
- All outputs are registered; every response appears in the cycle after the triggering `retired` or `start`.
- `redirect_valid` rises 1 cycle after the matching retirement. It is low in the cycle after `redirect_ack` is sampled high. An ack without valid is ignored.
- `pass_stb` is exactly one cycle wide per matching retirement.
- Simultaneous events:
  - Fail/end match and limit reached in the same cycle: the fail/end match wins over TIMEOUT.
  - `start` and `clear` in the same cycle: `clear` wins.
  - `start` outside IDLE is ignored.
- `reset` mid-run, including during REDIRECT, returns everything to reset values on the next edge and drops `redirect_valid`.
- `skip_count` saturates at 255. `pass_count` cannot exceed N_PASS.

## Test plan
- Program pass label 12; retire a CONT opcode (sqi=14, map=0, a=12) → `pass_stb`=1, `pass_idx`=0, `pass_count`=1. Retire it again → `pass_stb` pulses, `pass_count` stays 1.
- Program skip 43→44, target 53; retire `pc_x`=43 with `pc_f`=44 → `redirect_valid`=1 with `redirect_addr`=53. The request holds for 3 cycles without ack. Retirements during that time are ignored. After ack, state=RUN and `skip_count`=1.
- Program fail label 1666; retire `pc_x`=1666 → state=FAILED, `fail_pc`=1666, `done`=1. A later `start` is ignored; `clear` → IDLE.
- With `REQUIRE_ALL`=1, two pass entries, only one hit, retire the end label 1564 → FAILED. Repeat with both entries hit → PASSED.
- Set limit 100 with no end retirement → TIMEOUT on cycle 100 after `start`. Repeat with fail matched on the same cycle the limit is reached → FAILED.
- Assert `reset` while `redirect_valid`=1 → next cycle: state=IDLE, all outputs 0, all table entries invalid.
